delay_calib_ctrl: RTL and testbench

// - Synchronous calibration controller for a tap-selectable asymmetric delay line (bundled-data matched delay).
// - Fires req pulses into the line, times the synchronized ack rise in clk cycles, and steps the tap select

---
 rtl/delay_calib_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_delay_calib_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_calib_ctrl.sv
// Calibration controller for a tap-selectable bundled-data delay line: steps the tap upward until the
// measured req->ack delay reaches target. Optional build macro CALIB_AVG_EN averages 4 measurements per tap.
module delay_calib_ctrl #(
    parameter int TAP_W       = 4,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] target_cycles,
    output logic             dly_req,
    input  logic             dly_ack,
    output logic [TAP_W-1:0] dly_tap,
    output logic             busy,
    output logic             done,
    output logic             sat,
    output logic             timeout_err,
    output logic [CNT_W-1:0] meas_cycles
);

    typedef enum logic [2:0] {
        IDLE, SETTLE, FIRE, WAIT_RISE, WAIT_FALL, EVAL, FINISH
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [TAP_W-1:0] TAP_MAX   = {TAP_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic [TAP_W-1:0]       tap_q, tap_d;
    logic                   busy_q, busy_d;
    logic                   sat_q, sat_d;
    logic                   to_q, to_d;
    logic [CNT_W-1:0]       meas_q, meas_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       target_q, target_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
`ifdef CALIB_AVG_EN
    logic [1:0]             rep_q, rep_d;
    logic [CNT_W+1:0]       sum_q, sum_d, sum_next;
`endif

    assign ack_s   = sync_q[SYNC_STAGES-1];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
        state_d  = state_q;
        req_d    = req_q;
        tap_d    = tap_q;
        busy_d   = busy_q;
        sat_d    = sat_q;
        to_d     = to_q;
        meas_d   = meas_q;
        cnt_d    = cnt_q;
        target_d = target_q;
`ifdef CALIB_AVG_EN
        rep_d    = rep_q;
        sum_d    = sum_q;
        sum_next = sum_q + {2'b00, cnt_inc};
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    target_d = target_cycles;
                    sat_d    = 1'b0;
                    to_d     = 1'b0;
                    tap_d    = '0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
`ifdef CALIB_AVG_EN
                    rep_d    = '0;
                    sum_d    = '0;
`endif
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(1)) state_d = FIRE;
                else                    cnt_d   = cnt_inc;
            end
            FIRE: begin
                req_d   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (ack_s) begin
                    // The sampling edge itself is counted, hence cnt+1.
`ifdef CALIB_AVG_EN
                    sum_d = sum_next;
                    if (rep_q == 2'd3) meas_d = sum_next[CNT_W+1:2];
`else
                    meas_d = cnt_inc;
`endif
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_FALL;
                end else if (cnt_q == TIMEOUT_C) begin
                    to_d    = 1'b1;
                    req_d   = 1'b0;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_FALL: begin
                if (!ack_s) begin
`ifdef CALIB_AVG_EN
                    if (rep_q == 2'd3) begin
                        state_d = EVAL;
                    end else begin
                        rep_d   = rep_q + 1'b1;
                        state_d = FIRE;
                    end
`else
                    state_d = EVAL;
`endif
                end else if (cnt_q == TIMEOUT_C) begin
                    to_d    = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            EVAL: begin
                if (meas_q >= target_q) begin
                    state_d = FINISH;
                end else if (tap_q == TAP_MAX) begin
                    sat_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    // Safe to move the tap: req is low and ack has already returned low.
                    tap_d   = tap_q + 1'b1;
                    cnt_d   = '0;
`ifdef CALIB_AVG_EN
                    rep_d   = '0;
                    sum_d   = '0;
`endif
                    state_d = SETTLE;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            tap_q    <= '0;
            busy_q   <= 1'b0;
            sat_q    <= 1'b0;
            to_q     <= 1'b0;
            meas_q   <= '0;
            cnt_q    <= '0;
            target_q <= '0;
            sync_q   <= '0;
`ifdef CALIB_AVG_EN
            rep_q    <= '0;
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            tap_q    <= tap_d;
            busy_q   <= busy_d;
            sat_q    <= sat_d;
            to_q     <= to_d;
            meas_q   <= meas_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], dly_ack};
`ifdef CALIB_AVG_EN
            rep_q    <= rep_d;
            sum_q    <= sum_d;
`endif
        end
    end

    assign dly_req     = req_q;
    assign dly_tap     = tap_q;
    assign busy        = busy_q;
    assign done        = (state_q == FINISH);
    assign sat         = sat_q;
    assign timeout_err = to_q;
    assign meas_cycles = meas_q;

endmodule

// File: tb/tb_delay_calib_ctrl.sv
// Self-checking bench for delay_calib_ctrl: table of calibration runs against a delay-line model whose ack
// is first seen by the synchronizer (tap+3) edges after req rises, plus timeout/reset/start corner sequences.
module tb_delay_calib_ctrl;

    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] target_cycles;
    logic       dly_req;
    logic       dly_ack;
    logic [3:0] dly_tap;
    logic       busy;
    logic       done;
    logic       sat;
    logic       timeout_err;
    logic [7:0] meas_cycles;

    delay_calib_ctrl #(
        .TAP_W(4), .CNT_W(8), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .target_cycles(target_cycles),
        .dly_req(dly_req), .dly_ack(dly_ack), .dly_tap(dly_tap), .busy(busy),
        .done(done), .sat(sat), .timeout_err(timeout_err), .meas_cycles(meas_cycles)
    );

    always #5 clk = ~clk;

    // Delay-line model. mode 0: ack follows req; 1: ack stuck low; 2: ack sticks high once it rises.
    int          mode = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] req_hist = '0;
    logic        ack_latch = 1'b0;
    logic [4:0]  hist_idx;
    logic        model_ack;

    assign hist_idx  = {1'b0, dly_tap} + 5'd1;
    assign model_ack = req_hist[hist_idx];
    assign dly_ack   = (mode == 1) ? 1'b0 : (mode == 2) ? (model_ack | ack_latch) : model_ack;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (rst) req_hist <= '0;
        else     req_hist <= {req_hist[30:0], dly_req};
        if (mode != 2) ack_latch <= 1'b0;
        else           ack_latch <= ack_latch | model_ack;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic pulse_start(input logic [7:0] tgt);
        @(negedge clk);
        target_cycles = tgt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        target_cycles = '0;
    endtask

    typedef struct {
        logic [7:0] tgt;
        int         mode;
        int         meas;
        int         tap;
        int         sat;
        int         to;
    } vec_t;

    vec_t vecs[9];
    int   d0, c0, c1;
    bit   seen;

    initial begin
        // {target, ack mode, expected meas, tap, sat, timeout_err}
        vecs[0] = '{8'd8,   0,  8,  3, 0, 0};
        vecs[1] = '{8'd255, 0, 20, 15, 1, 0};
        vecs[2] = '{8'd0,   0,  5,  0, 0, 0};
        vecs[3] = '{8'd5,   0,  5,  0, 0, 0};
        vecs[4] = '{8'd6,   0,  6,  1, 0, 0};
        vecs[5] = '{8'd20,  0, 20, 15, 0, 0};
        vecs[6] = '{8'd21,  0, 20, 15, 1, 0};
        vecs[7] = '{8'd8,   2,  5,  0, 0, 1};
        vecs[8] = '{8'd8,   0,  8,  3, 0, 0};

        rst = 1'b1;
        start = 1'b0;
        target_cycles = '0;
        repeat (3) @(negedge clk);
        check("rst_req",  32'(dly_req), 0);
        check("rst_tap",  32'(dly_tap), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sat",  32'(sat), 0);
        check("rst_to",   32'(timeout_err), 0);
        check("rst_meas", 32'(meas_cycles), 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            mode = vecs[k].mode;
            repeat (8) @(negedge clk);
            d0 = done_cnt;
            pulse_start(vecs[k].tgt);
            wait_done($sformatf("v%0d", k), 3000);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_meas", k), 32'(meas_cycles), 32'(vecs[k].meas));
            check($sformatf("v%0d_tap", k),  32'(dly_tap), 32'(vecs[k].tap));
            check($sformatf("v%0d_sat", k),  32'(sat), 32'(vecs[k].sat));
            check($sformatf("v%0d_to", k),   32'(timeout_err), 32'(vecs[k].to));
            check($sformatf("v%0d_busy", k), 32'(busy), 0);
            check($sformatf("v%0d_req", k),  32'(dly_req), 0);
            check($sformatf("v%0d_ndone", k), 32'(done_cnt - d0), 1);
        end

        // ack stuck low: timeout_err exactly TIMEOUT+1 cycles after dly_req rises
        mode = 1;
        repeat (8) @(negedge clk);
        d0 = done_cnt;
        pulse_start(8'd8);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (dly_req) seen = 1'b1;
            else @(negedge clk);
        end
        check("to_req_rose", 32'(seen), 1);
        c0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < 2 * TIMEOUT && !seen; i++) begin
            @(negedge clk);
            if (timeout_err) seen = 1'b1;
        end
        c1 = cyc;
        check("to_seen", 32'(seen), 1);
        check("to_latency", 32'(c1 - c0), 32'(TIMEOUT + 1));
        check("to_req_low", 32'(dly_req), 0);
        repeat (2) @(negedge clk);
        check("to_busy", 32'(busy), 0);
        check("to_tap", 32'(dly_tap), 0);
        check("to_ndone", 32'(done_cnt - d0), 1);

        // reset in WAIT_RISE at tap 2, then a clean recalibration
        mode = 0;
        repeat (8) @(negedge clk);
        pulse_start(8'd255);
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (dly_req && dly_tap == 4'd2) seen = 1'b1;
        end
        check("mid_reached_tap2", 32'(seen), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_req",  32'(dly_req), 0);
        check("mid_tap",  32'(dly_tap), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_meas", 32'(meas_cycles), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        pulse_start(8'd8);
        wait_done("recal", 3000);
        @(negedge clk);
        check("recal_tap",  32'(dly_tap), 3);
        check("recal_meas", 32'(meas_cycles), 8);

        // second start while busy must not replace the target
        repeat (8) @(negedge clk);
        d0 = done_cnt;
        pulse_start(8'd8);
        repeat (2) @(negedge clk);
        pulse_start(8'd3);
        wait_done("busy_start", 3000);
        repeat (2) @(negedge clk);
        check("busy_start_tap",   32'(dly_tap), 3);
        check("busy_start_meas",  32'(meas_cycles), 8);
        check("busy_start_ndone", 32'(done_cnt - d0), 1);

        // start and rst in the same cycle: reset wins
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        target_cycles = 8'd8;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 0);
        @(negedge clk);
        check("rst_start_busy2", 32'(busy), 0);
        check("rst_start_req",   32'(dly_req), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
